// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : 2-read/1-write register file with a per-register busy scoreboard
//            and optional write-through bypass for RAW hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   reg_1_sel,
    input  logic [AW-1:0]   reg_2_sel,
    output logic [XLEN-1:0] reg_1,
    output logic [XLEN-1:0] reg_2,
    output logic            reg_1_busy,
    output logic            reg_2_busy,
    input  logic            write,
    input  logic [AW-1:0]   write_reg,
    input  logic [XLEN-1:0] write_data,
    input  logic            issue,
    input  logic [AW-1:0]   issue_reg,
    output logic            issue_waw,
    output logic [CW-1:0]   pending_count,
    output logic            all_idle
);

    localparam int c_DEPTH = 1 << AW;

    // Select codes that name a real, writable register; everything else reads as 0.
    function automatic logic [c_DEPTH-1:0] legal_mask();
        logic [c_DEPTH-1:0] m;
        for (int i = 0; i < c_DEPTH; i++) begin
            m[i] = (i < NREGS) && !((ZERO_REG != 0) && (i == 0));
        end
        return m;
    endfunction

    localparam logic [c_DEPTH-1:0] c_LEGAL = legal_mask();

    logic [XLEN-1:0]    r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [CW-1:0]      r_count;

    logic               w_wr_ok;
    logic               w_is_ok;
    logic               w_inc;
    logic               w_dec;
    logic [c_DEPTH-1:0] w_busy_nxt;
    logic [AW-1:0]      w_sel   [2];
    logic [XLEN-1:0]    w_rdata [2];
    logic [1:0]         w_rbusy;

    assign w_wr_ok = write && c_LEGAL[write_reg];
    assign w_is_ok = issue && c_LEGAL[issue_reg];

    // A same-register issue+write leaves the bit set, so the write's decrement is cancelled.
    assign w_inc = w_is_ok && !r_busy[issue_reg];
    assign w_dec = w_wr_ok && r_busy[write_reg] && !(w_is_ok && (issue_reg == write_reg));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[write_reg] = 1'b0;
        end
        if (w_is_ok) begin
            w_busy_nxt[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[write_reg] <= write_data;
            end
            r_busy <= w_busy_nxt;
            case ({w_inc, w_dec})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_sel[0] = reg_1_sel;
    assign w_sel[1] = reg_2_sel;

    for (genvar p = 0; p < 2; p++) begin : g_rdport
        logic w_hit;
        assign w_hit      = (BYPASS != 0) && w_wr_ok && (write_reg == w_sel[p]);
        assign w_rdata[p] = !c_LEGAL[w_sel[p]] ? '0 :
                            w_hit              ? write_data :
                                                 r_regs[w_sel[p]];
        assign w_rbusy[p] = c_LEGAL[w_sel[p]] && r_busy[w_sel[p]] && !w_hit;
    end

    assign reg_1         = w_rdata[0];
    assign reg_2         = w_rdata[1];
    assign reg_1_busy    = w_rbusy[0];
    assign reg_2_busy    = w_rbusy[1];
    assign issue_waw     = w_is_ok && r_busy[issue_reg];
    assign pending_count = r_count;
    assign all_idle      = (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed, table-driven bench for regfile_scoreboard (bypass and
//            non-bypass / non-power-of-two instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  sel1, sel2, wreg, ireg;
    logic        wr, iss;
    logic [31:0] wdata;

    logic [31:0] r1, r2;
    logic        b1, b2, waw, idle;
    logic [5:0]  cnt;

    logic [31:0] nb_r1, nb_r2;
    logic        nb_b1, nb_b2, nb_waw, nb_idle;
    logic [4:0]  nb_cnt;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clk), .reset(rst),
        .reg_1_sel(sel1), .reg_2_sel(sel2),
        .reg_1(r1), .reg_2(r2), .reg_1_busy(b1), .reg_2_busy(b2),
        .write(wr), .write_reg(wreg), .write_data(wdata),
        .issue(iss), .issue_reg(ireg), .issue_waw(waw),
        .pending_count(cnt), .all_idle(idle)
    );

    // 24 registers on a 5-bit select: codes 24..31 are out of range.
    regfile_scoreboard #(.XLEN(32), .NREGS(24), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clk), .reset(rst),
        .reg_1_sel(sel1), .reg_2_sel(sel2),
        .reg_1(nb_r1), .reg_2(nb_r2), .reg_1_busy(nb_b1), .reg_2_busy(nb_b2),
        .write(wr), .write_reg(wreg), .write_data(wdata),
        .issue(iss), .issue_reg(ireg), .issue_waw(nb_waw),
        .pending_count(nb_cnt), .all_idle(nb_idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        w;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        is;
        logic [4:0]  ir;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        b1;
        logic        b2;
        logic        waw;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs [28];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [4:0] wr_r, input logic [31:0] wd,
                         input logic is, input logic [4:0] ir, input logic [4:0] s1,
                         input logic [4:0] s2);
        wr = w; wreg = wr_r; wdata = wd; iss = is; ireg = ir; sel1 = s1; sel2 = s2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          w  wr     wd            is ir     s1     s2     r1            r2            b1 b2 waw cnt
        vecs[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h0,        0, 0, 0, 6'd0};
        vecs[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd1,  5'd2,  32'h0,        32'h0,        0, 0, 0, 6'd0};
        vecs[2]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 6'd0};
        vecs[3]  = '{1, 5'd0,  32'h1,        0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 0, 0, 0, 6'd0};
        vecs[4]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 0, 0, 0, 6'd0};
        vecs[5]  = '{1, 5'd7,  32'h1234,     0, 5'd0,  5'd7,  5'd5,  32'h1234,     32'hDEADBEEF, 0, 0, 0, 6'd0};
        vecs[6]  = '{0, 5'd0,  32'h0,        1, 5'd3,  5'd3,  5'd7,  32'h0,        32'h1234,     0, 0, 0, 6'd0};
        vecs[7]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  5'd3,  32'h0,        32'h0,        1, 1, 0, 6'd1};
        vecs[8]  = '{1, 5'd3,  32'h55,       0, 5'd0,  5'd3,  5'd1,  32'h55,       32'h0,        0, 0, 0, 6'd1};
        vecs[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  5'd3,  32'h55,       32'h55,       0, 0, 0, 6'd0};
        vecs[10] = '{0, 5'd0,  32'h0,        1, 5'd4,  5'd4,  5'd7,  32'h0,        32'h1234,     0, 0, 0, 6'd0};
        vecs[11] = '{1, 5'd4,  32'h9,        1, 5'd4,  5'd4,  5'd4,  32'h9,        32'h9,        0, 0, 1, 6'd1};
        vecs[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd4,  5'd5,  32'h9,        32'hDEADBEEF, 1, 0, 0, 6'd1};
        vecs[13] = '{0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  5'd4,  32'h0,        32'h9,        0, 1, 0, 6'd1};
        vecs[14] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  5'd4,  32'h0,        32'h9,        0, 1, 0, 6'd1};
        vecs[15] = '{1, 5'd4,  32'hA,        0, 5'd0,  5'd4,  5'd5,  32'hA,        32'hDEADBEEF, 0, 0, 0, 6'd1};
        vecs[16] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd4,  5'd4,  32'hA,        32'hA,        0, 0, 0, 6'd0};
        vecs[17] = '{1, 5'd6,  32'h77,       0, 5'd0,  5'd6,  5'd0,  32'h77,       32'h0,        0, 0, 0, 6'd0};
        vecs[18] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd6,  5'd6,  32'h77,       32'h77,       0, 0, 0, 6'd0};
        vecs[19] = '{1, 5'd8,  32'h88,       1, 5'd8,  5'd8,  5'd6,  32'h88,       32'h77,       0, 0, 0, 6'd0};
        vecs[20] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd8,  5'd8,  32'h88,       32'h88,       1, 1, 0, 6'd1};
        vecs[21] = '{1, 5'd8,  32'h99,       0, 5'd0,  5'd8,  5'd6,  32'h99,       32'h77,       0, 0, 0, 6'd1};
        vecs[22] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd8,  5'd8,  32'h99,       32'h99,       0, 0, 0, 6'd0};
        vecs[23] = '{0, 5'd0,  32'h0,        1, 5'd9,  5'd9,  5'd10, 32'h0,        32'h0,        0, 0, 0, 6'd0};
        vecs[24] = '{1, 5'd9,  32'h11,       1, 5'd10, 5'd9,  5'd10, 32'h11,       32'h0,        0, 0, 0, 6'd1};
        vecs[25] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd9,  5'd10, 32'h11,       32'h0,        0, 1, 0, 6'd1};
        vecs[26] = '{1, 5'd10, 32'h22,       0, 5'd0,  5'd10, 5'd9,  32'h22,       32'h11,       0, 0, 0, 6'd1};
        vecs[27] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd10, 5'd9,  32'h22,       32'h11,       0, 0, 0, 6'd0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset count", cnt, 0);
        chk("reset idle", idle, 1);
        chk("reset r2", r2, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].w, vecs[i].wr, vecs[i].wd, vecs[i].is, vecs[i].ir, vecs[i].s1, vecs[i].s2);
            @(negedge clk);
            chk($sformatf("v%0d reg_1", i), r1, vecs[i].r1);
            chk($sformatf("v%0d reg_2", i), r2, vecs[i].r2);
            chk($sformatf("v%0d reg_1_busy", i), b1, vecs[i].b1);
            chk($sformatf("v%0d reg_2_busy", i), b2, vecs[i].b2);
            chk($sformatf("v%0d issue_waw", i), waw, vecs[i].waw);
            chk($sformatf("v%0d pending_count", i), cnt, vecs[i].cnt);
            chk($sformatf("v%0d all_idle", i), idle, (vecs[i].cnt == 6'd0));
            step();
        end

        // No bypass: old data and raw busy stay visible during the write cycle.
        drive(1, 5'd7, 32'h5678, 0, 0, 5'd7, 5'd7);
        @(negedge clk);
        chk("nb old data", nb_r1, 32'h1234);
        chk("byp new data", r1, 32'h5678);
        step();
        drive(0, 0, 0, 0, 0, 5'd7, 5'd7);
        @(negedge clk);
        chk("nb new data", nb_r1, 32'h5678);
        step();
        drive(0, 0, 0, 1, 5'd11, 5'd11, 5'd11);
        step();
        drive(1, 5'd11, 32'h1, 0, 0, 5'd11, 5'd11);
        @(negedge clk);
        chk("nb busy on write", nb_b1, 1);
        chk("nb data on write", nb_r1, 0);
        chk("byp busy on write", b1, 0);
        step();
        drive(0, 0, 0, 0, 0, 5'd11, 5'd11);
        @(negedge clk);
        chk("nb count cleared", nb_cnt, 0);
        chk("count cleared", cnt, 0);
        step();

        // Out-of-range selects on the 24-register instance.
        drive(1, 5'd25, 32'hFFFF, 1, 5'd26, 5'd25, 5'd26);
        @(negedge clk);
        chk("oor waw nb", nb_waw, 0);
        chk("oor waw", waw, 0);
        step();
        drive(0, 0, 0, 0, 0, 5'd25, 5'd26);
        @(negedge clk);
        chk("oor nb data", nb_r1, 0);
        chk("oor nb busy", nb_b2, 0);
        chk("oor nb count", nb_cnt, 0);
        chk("inrange data", r1, 32'hFFFF);
        chk("inrange busy", b2, 1);
        chk("inrange count", cnt, 1);
        step();
        drive(1, 5'd26, 32'h0, 0, 0, 5'd0, 5'd0);
        step();

        // Fill every register, then drain.
        for (int r = 1; r < 32; r++) begin
            drive(0, 0, 0, 1, 5'(r), 5'd0, 5'd0);
            step();
        end
        drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        chk("fill r0 waw", waw, 0);
        step();
        drive(0, 0, 0, 1, 5'd31, 5'd31, 5'd1);
        @(negedge clk);
        chk("fill waw r31", waw, 1);
        chk("fill count", cnt, 31);
        chk("fill idle", idle, 0);
        chk("fill nb count", nb_cnt, 23);
        chk("fill busy r31", b1, 1);
        step();
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0);
        @(negedge clk);
        chk("fill count after waw", cnt, 31);
        for (int r = 1; r < 32; r++) begin
            drive(1, 5'(r), 32'(r), 0, 0, 5'd0, 5'd0);
            step();
        end
        drive(0, 0, 0, 0, 0, 5'd30, 5'd31);
        @(negedge clk);
        chk("drain count", cnt, 0);
        chk("drain idle", idle, 1);
        chk("drain nb count", nb_cnt, 0);
        chk("drain data r30", r1, 32'd30);
        chk("drain busy r31", b2, 0);
        step();

        // Asynchronous reset in mid-cycle with a register pending.
        drive(0, 0, 0, 1, 5'd2, 5'd5, 5'd2);
        step();
        drive(0, 0, 0, 0, 0, 5'd5, 5'd2);
        @(negedge clk);
        chk("pre-reset count", cnt, 1);
        chk("pre-reset data", r1, 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async reset r1", r1, 0);
        chk("async reset r2", r2, 0);
        chk("async reset busy", b2, 0);
        chk("async reset count", cnt, 0);
        chk("async reset idle", idle, 1);
        @(negedge clk);
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("post-reset data", r1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
